// File: rtl/stopwatch_top.sv
// stopwatch_top: MM:SS stopwatch with adjust/pause control, driving a 4-digit
// multiplexed active-low 7-segment display.
module stopwatch_top #(
  parameter int ONE_HZ_DIV  = 100000000,
  parameter int TWO_HZ_DIV  = 50000000,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       adj,
  input  logic       pause,
  output logic [3:0] anode_vec,
  output logic [6:0] cathode_vec
);
  localparam int W1 = ONE_HZ_DIV > 1 ? $clog2(ONE_HZ_DIV) : 1;
  localparam int W2 = TWO_HZ_DIV > 1 ? $clog2(TWO_HZ_DIV) : 1;
  localparam int WR = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int WB = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [W1-1:0] one_q, one_d;
  logic [W2-1:0] two_q, two_d;
  logic [WR-1:0] ref_q, ref_d;
  logic [WB-1:0] blk_q, blk_d;
  logic one_tick, two_tick, ref_tick, blk_tick;
  logic [1:0] sel_q, adj_q, pause_q;
  logic pause_prev_q, paused_q, paused_d;
  logic [3:0] sec_o_q, sec_o_d, sec_t_q, sec_t_d, min_o_q, min_o_d, min_t_q, min_t_d;
  logic [1:0] scan_q, scan_d;
  logic blink_q, blink_d;
  logic [3:0] anode_q, anode_d, digit;
  logic [6:0] cathode_q, cathode_d, seg;
  logic adj_s, sel_s, run, sec_max, min_max, inc_s, inc_m;
  always_comb begin
    one_tick = one_q == W1'(ONE_HZ_DIV - 1);
    two_tick = two_q == W2'(TWO_HZ_DIV - 1);
    ref_tick = ref_q == WR'(REFRESH_DIV - 1);
    blk_tick = blk_q == WB'(BLINK_DIV - 1);
    one_d = one_tick ? '0 : one_q + W1'(1);
    two_d = two_tick ? '0 : two_q + W2'(1);
    ref_d = ref_tick ? '0 : ref_q + WR'(1);
    blk_d = blk_tick ? '0 : blk_q + WB'(1);
    adj_s = adj_q[1];
    sel_s = sel_q[1];
    paused_d = paused_q ^ (pause_q[1] & ~pause_prev_q);
    run = !paused_q;
    sec_max = sec_t_q == 4'd5 && sec_o_q == 4'd9;
    min_max = min_t_q == 4'd5 && min_o_q == 4'd9;
    // Adjust mode bumps one field with no carry; normal mode carries seconds into minutes
    inc_s = run && (adj_s ? two_tick && sel_s : one_tick);
    inc_m = run && (adj_s ? two_tick && !sel_s : one_tick && sec_max);
    sec_o_d = !inc_s ? sec_o_q : sec_o_q == 4'd9 ? 4'd0 : sec_o_q + 4'd1;
    sec_t_d = !inc_s || sec_o_q != 4'd9 ? sec_t_q : sec_max ? 4'd0 : sec_t_q + 4'd1;
    min_o_d = !inc_m ? min_o_q : min_o_q == 4'd9 ? 4'd0 : min_o_q + 4'd1;
    min_t_d = !inc_m || min_o_q != 4'd9 ? min_t_q : min_max ? 4'd0 : min_t_q + 4'd1;
    scan_d = scan_q + {1'b0, ref_tick};
    blink_d = blink_q ^ blk_tick;
    digit = scan_q == 2'd0 ? sec_o_q : scan_q == 2'd1 ? sec_t_q : scan_q == 2'd2 ? min_o_q : min_t_q;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    anode_d = ~(4'b0001 << scan_q);
    // scan_q[1] marks the minutes digits; blank whichever field is being adjusted
    cathode_d = adj_s && blink_q && (sel_s ^ scan_q[1]) ? 7'b1111111 : seg;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      one_q <= '0;
      two_q <= '0;
      ref_q <= '0;
      blk_q <= '0;
      sel_q <= '0;
      adj_q <= '0;
      pause_q <= '0;
      pause_prev_q <= 1'b0;
      paused_q <= 1'b0;
      sec_o_q <= '0;
      sec_t_q <= '0;
      min_o_q <= '0;
      min_t_q <= '0;
      scan_q <= '0;
      blink_q <= 1'b0;
      anode_q <= '1;
      cathode_q <= '1;
    end else begin
      one_q <= one_d;
      two_q <= two_d;
      ref_q <= ref_d;
      blk_q <= blk_d;
      sel_q <= {sel_q[0], sel};
      adj_q <= {adj_q[0], adj};
      pause_q <= {pause_q[0], pause};
      pause_prev_q <= pause_q[1];
      paused_q <= paused_d;
      sec_o_q <= sec_o_d;
      sec_t_q <= sec_t_d;
      min_o_q <= min_o_d;
      min_t_q <= min_t_d;
      scan_q <= scan_d;
      blink_q <= blink_d;
      anode_q <= anode_d;
      cathode_q <= cathode_d;
    end
  end
  assign anode_vec = anode_q;
  assign cathode_vec = cathode_q;
endmodule

// File: tb/tb_stopwatch_top.sv
// tb_stopwatch_top: stopwatch bench; a time-based reference model predicts the
// displayed digit every cycle, and directed scenarios read the display back as MM:SS.
module tb_stopwatch_top;
  localparam int OD = 10, TD = 5, RD = 2, BD = 4;
  logic clk = 1'b0, rst = 1'b0, sel = 1'b0, adj = 1'b0, pause = 1'b0;
  logic [3:0] anode_vec;
  logic [6:0] cathode_vec;
  int total = 0, bad = 0;
  int n = 0, mm = 0, ms = 0;
  bit mp = 1'b0;
  bit [2:0] ah = '0, sh = '0, ph = '0;
  logic [3:0] ex_an = 4'hF;
  logic [6:0] ex_cat = 7'h7F;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  stopwatch_top #(.ONE_HZ_DIV(OD), .TWO_HZ_DIV(TD), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .adj(adj), .pause(pause),
    .anode_vec(anode_vec), .cathode_vec(cathode_vec));

  always #5 clk = ~clk;

  function automatic int dec(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (segs[i] === c) return i;
    return 15;
  endfunction

  // One clock edge of the model: n counts edges since reset; inputs reach the
  // control logic two edges after they are sampled.
  task automatic step();
    int sc, dg;
    bit ae, se, rise, blank;
    @(posedge clk);
    if (!rst) begin
      n = 0; mm = 0; ms = 0; mp = 1'b0; ah = '0; sh = '0; ph = '0;
      ex_an = 4'hF; ex_cat = 7'h7F;
    end else begin
      ae = ah[1]; se = sh[1]; rise = ph[1] && !ph[2];
      sc = (n / RD) % 4;
      dg = sc == 0 ? ms % 10 : sc == 1 ? ms / 10 : sc == 2 ? mm % 10 : mm / 10;
      blank = ae && ((n / BD) % 2 == 1) && (se ? sc < 2 : sc >= 2);
      ex_an = ~(4'b0001 << sc);
      ex_cat = blank ? 7'h7F : segs[dg];
      if (!mp) begin
        if (!ae && n % OD == OD - 1) begin
          ms = ms + 1;
          if (ms == 60) begin ms = 0; mm = (mm + 1) % 60; end
        end else if (ae && n % TD == TD - 1) begin
          if (se) ms = (ms + 1) % 60; else mm = (mm + 1) % 60;
        end
      end
      if (rise) mp = !mp;
      ah = {ah[1:0], adj}; sh = {sh[1:0], sel}; ph = {ph[1:0], pause};
      n++;
    end
    @(negedge clk);
  endtask

  // Pulse pause two edges clear of any count tick so a freeze/unfreeze never races one.
  task automatic pulse_pause();
    while (n % 5 != 0) step();
    pause = 1'b1; step(); pause = 1'b0; step(); step();
  endtask

  task automatic read_disp(output logic [15:0] v, output bit ok);
    bit [3:0] seen = '0;
    logic [3:0] a;
    v = '0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        a = ~(4'b0001 << k);
        if (anode_vec === a && cathode_vec !== 7'h7F) begin
          v[k*4 +: 4] = 4'(dec(cathode_vec)); seen[k] = 1'b1;
        end
      end
      ok = &seen;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) begin
      step(); total++;
      if (anode_vec !== 4'hF || cathode_vec !== 7'h7F) begin
        bad++; $display("FAIL reset got %b_%b want 1111_1111111", anode_vec, cathode_vec);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] a;
      step();
      a = ~(4'b0001 << (k / 2)); total++;
      if (anode_vec !== a || cathode_vec !== 7'b1000000) begin
        bad++; $display("FAIL first_scan k=%0d got %b_%b want %b_1000000", k, anode_vec, cathode_vec, a);
      end
    end
  endtask

  task automatic test_count();
    logic [15:0] v; bit ok;
    while (n < 600) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL count n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    pulse_pause();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0100) begin bad++; $display("FAIL count_60s got %h ok=%0d want 0100", v, ok); end
    adj = 1'b1; sel = 1'b0; step(); step(); step();
    pulse_pause();
    for (int i = 0; i < 400 && mm != 59; i++) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL preload_min n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    sel = 1'b1;
    for (int i = 0; i < 400 && ms != 59; i++) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL preload_sec n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    pulse_pause();
    adj = 1'b0; step(); step(); step();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h5959) begin bad++; $display("FAIL preload got %h ok=%0d want 5959", v, ok); end
    pulse_pause();
    for (int i = 0; i < 30 && !(mm == 0 && ms == 0); i++) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL wrap n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    pulse_pause();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0000) begin bad++; $display("FAIL wrap got %h ok=%0d want 0000", v, ok); end
  endtask

  task automatic test_adjust_min();
    logic [15:0] v; bit ok;
    adj = 1'b1; sel = 1'b0; step(); step(); step();
    pulse_pause();
    repeat (12) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL adj_min n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
      if (anode_vec == 4'b0111 || anode_vec == 4'b1011) begin
        total++;
        if (cathode_vec !== 7'h7F) begin bad++; $display("FAIL blink an=%b got %b want 1111111", anode_vec, cathode_vec); end
      end
    end
    pulse_pause();
    adj = 1'b0; step(); step(); step();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0300) begin bad++; $display("FAIL adj_min got %h ok=%0d want 0300", v, ok); end
  endtask

  task automatic test_adjust_sec();
    logic [15:0] v; bit ok;
    adj = 1'b1; sel = 1'b1; step(); step(); step();
    pulse_pause();
    for (int i = 0; i < 400 && ms != 59; i++) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL adj_sec n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    pulse_pause();
    adj = 1'b0; step(); step(); step();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0359) begin bad++; $display("FAIL adj_sec59 got %h ok=%0d want 0359", v, ok); end
    adj = 1'b1; step(); step(); step();
    pulse_pause();
    step(); step();
    pulse_pause();
    adj = 1'b0; step(); step(); step();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0300) begin bad++; $display("FAIL adj_sec_nocarry got %h ok=%0d want 0300", v, ok); end
  endtask

  task automatic test_pause();
    logic [15:0] v; bit ok;
    pulse_pause();
    repeat (27) step();
    pulse_pause();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0303) begin bad++; $display("FAIL resume got %h ok=%0d want 0303", v, ok); end
    repeat (50) begin
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL frozen n=%0d got %b_%b want %b_%b", n, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0303) begin bad++; $display("FAIL frozen got %h ok=%0d want 0303", v, ok); end
    pulse_pause();
    for (int i = 0; i < 10 && n % 10 != 0; i++) step();
    pulse_pause();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0304) begin bad++; $display("FAIL one_tick got %h ok=%0d want 0304", v, ok); end
  endtask

  task automatic test_toggle_tick();
    logic [15:0] v; bit ok;
    // Toggle lands on the edge carrying a tick: the tick still sees paused=1
    for (int i = 0; i < 10 && n % 10 != 7; i++) step();
    pause = 1'b1; step(); pause = 1'b0; step(); step();
    for (int i = 0; i < 10 && n % 5 != 0; i++) step();
    pulse_pause();
    read_disp(v, ok); total++;
    if (!ok || v !== 16'h0304) begin bad++; $display("FAIL toggle_tick got %h ok=%0d want 0304", v, ok); end
  endtask

  task automatic test_scan();
    logic [3:0] an_e [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] cat_e [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    int w;
    rst = 1'b0; adj = 1'b1; sel = 1'b0; step(); step(); rst = 1'b1;
    for (int i = 0; i < 200 && mm != 12; i++) step();
    sel = 1'b1;
    for (int i = 0; i < 400 && ms != 34; i++) step();
    pulse_pause();
    adj = 1'b0; step(); step(); step();
    w = 0;
    while (w < 16 && anode_vec !== 4'b0111) begin step(); w++; end
    while (w < 16 && anode_vec !== 4'b1110) begin step(); w++; end
    total++;
    if (w >= 16) begin bad++; $display("FAIL scan_wait got %b want 1110 within 16 cycles", anode_vec); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (anode_vec !== an_e[k/2] || cathode_vec !== cat_e[k/2]) begin
        bad++; $display("FAIL scan k=%0d got %b_%b want %b_%b", k, anode_vec, cathode_vec, an_e[k/2], cat_e[k/2]);
      end
      step();
    end
  endtask

  task automatic test_random();
    rst = 1'b0; step(); step(); rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) adj = ~adj;
      if ($urandom_range(19) == 0) sel = ~sel;
      pause = $urandom_range(15) == 0;
      rst = !(i == 700 || i == 701);
      step(); total++;
      if ({anode_vec, cathode_vec} !== {ex_an, ex_cat}) begin
        bad++; $display("FAIL random i=%0d got %b_%b want %b_%b", i, anode_vec, cathode_vec, ex_an, ex_cat);
      end
    end
    rst = 1'b1; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_adjust_min();
    test_adjust_sec();
    test_pause();
    test_toggle_tick();
    test_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_top.md
Name: stopwatch_top

Overview:
- Top level of the MM:SS stopwatch on a 4-digit multiplexed 7-segment display.
- Contains the clock-enable dividers, the minutes/seconds counters, the adjust/pause control and the display multiplexer with decoder.
- Inputs are the board switches (sel, adj), the pause button and one system clock.
- Outputs drive the anodes and cathodes directly.

Parameters:
- ONE_HZ_DIV, 100000000: clock cycles per count tick (1 Hz).
- TWO_HZ_DIV, 50000000: clock cycles per adjust tick (2 Hz).
- REFRESH_DIV, 100000: clock cycles per display digit advance.
- BLINK_DIV, 25000000: clock cycles per blink phase toggle.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset. Reset applies while rst=0.
- sel  in  1  adjust select switch: 0 = minutes, 1 = seconds.
- adj  in  1  adjust mode switch: 1 = adjust, 0 = normal count.
- pause  in  1  pause button, asynchronous, active-high.
- anode_vec  out  4  active-low digit enables. Bit0 = rightmost digit.
- cathode_vec  out  7  active-low segments, [6:0] = {g,f,e,d,c,b,a}.

Behaviour:
Clocking and reset:
- One clock. Reset is synchronous and active-low.
- Every register updates only on the clk rising edge; rst is sampled there.

Reset state (while rst=0):
- minutes = 0, seconds = 0, paused = 0.
- All divider counters = 0, scan index = 0, blink phase = 0 (visible).
- anode_vec = 4'b1111, cathode_vec = 7'b1111111.

Input synchronisation:
- sel, adj and pause each pass through a 2-flop synchroniser.
- pause has a rising-edge detector after the synchroniser.
- Each detected rising edge toggles paused.
- The toggle takes effect on the 3rd clock edge after pause rises. Holding pause high toggles only once.

Dividers:
- Each divider is a free-running counter from 0 to DIV-1.
- It emits a one-cycle tick when the count equals DIV-1, then wraps to 0.
- Dividers run regardless of paused, adj and sel.

Normal mode (adj=0, paused=0), on each 1 Hz tick:
- seconds increments.
- seconds 59 -> 0 with a carry into minutes.
- minutes 59 -> 0, so 59:59 -> 00:00.

Adjust mode (adj=1, paused=0):
- The 1 Hz tick is ignored.
- On each 2 Hz tick, the selected field increments modulo 60.
- sel=0 selects minutes; sel=1 selects seconds.
- There is no carry between fields, so seconds 59 -> 0 leaves minutes unchanged.

Paused (paused=1):
- No counter changes in either mode.
- Display continues; blinking continues in adjust mode.

Field width:
- Each field is stored as two BCD digits (tens 0-5, ones 0-9), or as binary with conversion. The displayed value is identical either way.

Display scan:
- The scan index advances 0 -> 1 -> 2 -> 3 -> 0 on each refresh tick.
- Index 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
- anode_vec has exactly one bit low: bit = scan index.
- cathode_vec shows the digit for that scan index.

Blink:
- When adj=1, during blink phase 1 the digits of the selected field show cathode_vec = 7'b1111111. The anode is still driven.
- When adj=0, no blanking occurs.

Decoder (active-low, {g..a}):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

Simultaneous events:
- A pause toggle in the same cycle as a tick: the tick uses the pre-toggle paused value.
- Reset asserted mid-count overrides everything on that edge.

Test Plan:
Bench overrides ONE_HZ_DIV=10, TWO_HZ_DIV=5, REFRESH_DIV=2, BLINK_DIV=4.
1. Hold rst=0 for 5 cycles -> anode_vec=1111, cathode_vec=1111111. Release -> first refreshed digits show 00:00 (cathode 1000000 on all four anodes in turn).
2. Run normally for 60 one-Hz ticks (600 cycles) -> 01:00. Preload via adjust to 59:59, then one tick -> 00:00.
3. Set adj=1, sel=0 for 3 two-Hz ticks -> minutes +3, seconds unchanged. Anodes 0111/1011 blank during blink phase 1.
4. Set adj=1, sel=1 with seconds at 59, one 2 Hz tick -> seconds 00, minutes unchanged.
5. Pulse pause for 1 cycle -> counter frozen over 50 cycles. Pulse again -> counting resumes; toggle lands 3 cycles after the rising edge.
6. Scan check at value 12:34 -> anode 1110 shows 0011001 (4), 1101 shows 0110000 (3), 1011 shows 0100100 (2), 0111 shows 1111001 (1).
